max7219_receiver: RTL and testbench
===================================

MAX7219_RECEIVER -- requirements
Module: max7219_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in each serial input synchronizer; legal range 2-3.
REQ-002 SHALL have port i_clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port i_serial_din, input, 1 bit: serial data, MSB first.
REQ-005 SHALL have port i_serial_clk, input, 1 bit: serial clock, with data sampled on its rising edge.
REQ-006 SHALL have port i_serial_load, input, 1 bit: frame load, low during shifting; its rising edge latches the frame.
REQ-007 SHALL have port o_serial_dout, output, 1 bit: daisy-chain output, present only when the macro in Configuration is defined.
REQ-008 SHALL have port o_valid, output, 1 bit: one-cycle strobe marking a decoded frame.
REQ-009 SHALL have ports o_addr (4 bits) and o_data (8 bits), outputs: the last latched frame fields, held between frames.
REQ-010 SHALL have port o_frame_err, output, 1 bit: one-cycle strobe marking a short frame.
REQ-011 SHALL have port o_digits, output, 64 bits: digit register n at bits [8n-1:8n-8] for n = 1..8.
REQ-012 SHALL have ports o_decode_mode (8 bits), o_intensity (4 bits), o_scan_limit (3 bits), o_shutdown_n (1 bit) and o_display_test (1 bit), all outputs.

Function
REQ-013 SHALL pass i_serial_din, i_serial_clk and i_serial_load through SYNC_STAGES-deep synchronizers, then one edge-detect register each.
REQ-014 SHALL support a serial clock whose high and low phases each last at least 2 i_clk periods; faster serial clocks are out of scope.
REQ-015 SHALL implement a state machine with states IDLE and SHIFT.
REQ-016 SHALL transition IDLE->SHIFT on a synchronized load falling edge, clearing the 5-bit bit counter.
REQ-017 SHALL, in SHIFT, on each synchronized serial clock rising edge, shift din into bit 0 of a 16-bit shift register and increment the counter, saturating at 31.
REQ-018 SHALL, on a synchronized load rising edge in SHIFT with counter >= 16, latch the last 16 bits shifted in and return to IDLE.
REQ-019 SHALL, on a synchronized load rising edge in SHIFT with counter < 16, pulse o_frame_err for one cycle, leave all registers unchanged and return to IDLE.
REQ-020 SHALL ignore serial clock edges while in IDLE.
REQ-021 SHALL, when a serial clock rising edge and a load rising edge are detected in the same cycle, shift first and then evaluate the latch using the updated counter.
REQ-022 SHALL ignore frame bits [15:12]; the address is bits [11:8] and the data is bits [7:0].
REQ-023 SHALL decode addresses as follows: 0x1-0x8 -> digit 1-8; 0x9 -> decode_mode; 0xA -> intensity (data[3:0]); 0xB -> scan_limit (data[2:0]); 0xC -> shutdown_n (data[0]); 0xF -> display_test (data[0]).
REQ-024 SHALL treat addresses 0x0, 0xD and 0xE as no-ops: o_valid pulses but no display register changes.
REQ-025 SHALL assert o_valid, update o_addr/o_data and update the target register all in the same cycle, one i_clk after the edge-detect register flags the load rising edge.

Reset
REQ-026 SHALL, while i_reset is high, force state IDLE, counter 0, shift register 0, o_valid 0, o_frame_err 0, o_addr 0, o_data 0, o_digits 0, o_decode_mode 0, o_intensity 0, o_scan_limit 0, o_shutdown_n 0 and o_display_test 0.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame; after reset the block stays in IDLE until a new load falling edge.
REQ-028 SHALL reset the synchronizer flops to 1 for load and 0 for clk and din, so that releasing reset creates no spurious edges.

Configuration
REQ-029 SHALL, when macro MAX7219_RECEIVER_DOUT_EN is defined, provide o_serial_dout equal to the shift register bit 15, giving a 16-clock delayed daisy-chain output.
REQ-030 SHALL, when MAX7219_RECEIVER_DOUT_EN is undefined, omit port o_serial_dout and leave behaviour otherwise identical.

Structure
REQ-031 SHALL place the register address localparams (NOOP, DIGIT0-7, DECODE_MODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, DISPLAY_TEST) and the state encoding in shared package max7219_pkg, for reuse by the transmitter-side drivers.
REQ-032 SHALL implement a single sub-module, sync_edge (synchronizer plus rise/fall detect), instantiated three times.

Verification
REQ-033 SHALL verify: frame 0x0A05 at a serial clock of i_clk/8 -> one o_valid pulse, o_intensity=5, o_addr=0xA, o_data=0x05.
REQ-034 SHALL verify: 20-bit burst 0xF_0305 -> o_digits[23:16]=0x05 from the last 16 bits, o_serial_dout (when enabled) replays the first 4 bits 0xF.
REQ-035 SHALL verify: 12 bits then load high -> o_frame_err pulses once, no o_valid pulse, and all registers are unchanged.
REQ-036 SHALL verify: frame 0x0C01 then 0x0F01 -> o_shutdown_n=1 then o_display_test=1; frame 0x0D55 -> o_valid pulses and no register changes.
REQ-037 SHALL verify: i_reset high after 8 bits, then a full frame 0x0301 -> o_digits[23:16]=0x01 and no error pulse.
REQ-038 SHALL verify: last serial clock rising edge coincident with load rising edge -> the 16th bit is captured and the frame is valid.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map and receiver state encoding.
// Reused by the transmitter-side drivers so both ends agree on addresses.
package max7219_pkg;

    localparam logic [3:0] NOOP         = 4'h0;
    localparam logic [3:0] DIGIT0       = 4'h1;
    localparam logic [3:0] DIGIT1       = 4'h2;
    localparam logic [3:0] DIGIT2       = 4'h3;
    localparam logic [3:0] DIGIT3       = 4'h4;
    localparam logic [3:0] DIGIT4       = 4'h5;
    localparam logic [3:0] DIGIT5       = 4'h6;
    localparam logic [3:0] DIGIT6       = 4'h7;
    localparam logic [3:0] DIGIT7       = 4'h8;
    localparam logic [3:0] DECODE_MODE  = 4'h9;
    localparam logic [3:0] INTENSITY    = 4'hA;
    localparam logic [3:0] SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] SHUTDOWN     = 4'hC;
    localparam logic [3:0] DISPLAY_TEST = 4'hF;

    localparam int         FRAME_BITS = 16;
    localparam logic [4:0] CNT_MAX    = 5'd31;
    localparam logic [4:0] CNT_FRAME  = 5'd16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    // Bit counter saturates so over-long bursts still latch the last 16 bits.
    function automatic logic [4:0] sat_inc(input logic [4:0] value);
        return (value == CNT_MAX) ? value : value + 5'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by one edge-detect register.
// RESET_VAL matches the idle level of the line so reset release makes no edge.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_async};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_reg[SYNC_STAGES-1];
    assign o_rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    assign o_fall  = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver decoding frames into display registers.
// Define MAX7219_RECEIVER_DOUT_EN to add the o_serial_dout daisy-chain output.
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_serial_din,
    input  logic        i_serial_clk,
    input  logic        i_serial_load,
`ifdef MAX7219_RECEIVER_DOUT_EN
    output logic        o_serial_dout,
`endif
    output logic        o_valid,
    output logic [3:0]  o_addr,
    output logic [7:0]  o_data,
    output logic        o_frame_err,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test
);

    logic din_level, din_rise, din_fall;
    logic clk_level, clk_rise, clk_fall;
    logic load_level, load_rise, load_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_serial_din),
        .o_level(din_level), .o_rise(din_rise), .o_fall(din_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_serial_clk),
        .o_level(clk_level), .o_rise(clk_rise), .o_fall(clk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_serial_load),
        .o_level(load_level), .o_rise(load_rise), .o_fall(load_fall)
    );

    rx_state_t   state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_shift;
    logic [15:0] sr_reg, sr_shift;
    logic        shift_now, frame_ok, frame_bad;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;

    // A coincident clock edge is shifted before the load edge is judged.
    assign shift_now = (state_reg == ST_SHIFT) && clk_rise;
    assign cnt_shift = shift_now ? sat_inc(cnt_reg) : cnt_reg;
    assign sr_shift  = shift_now ? {sr_reg[14:0], din_level} : sr_reg;
    assign wr_addr   = sr_shift[11:8];
    assign wr_data   = sr_shift[7:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (load_fall) state_next = ST_SHIFT;
            ST_SHIFT: if (load_rise) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (state_reg == ST_SHIFT && load_rise) begin
            frame_ok  = (cnt_shift >= CNT_FRAME);
            frame_bad = (cnt_shift <  CNT_FRAME);
        end
    end

    logic       valid_reg, err_reg, shutdown_reg, test_reg;
    logic [3:0] addr_reg, intensity_reg;
    logic [7:0] data_reg, decode_reg;
    logic [2:0] scan_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_reg       <= '0;
            sr_reg        <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            decode_reg    <= '0;
            intensity_reg <= '0;
            scan_reg      <= '0;
            shutdown_reg  <= 1'b0;
            test_reg      <= 1'b0;
        end else begin
            cnt_reg   <= (state_reg == ST_IDLE && load_fall) ? 5'd0 : cnt_shift;
            sr_reg    <= sr_shift;
            valid_reg <= frame_ok;
            err_reg   <= frame_bad;
            if (frame_ok) begin
                addr_reg <= wr_addr;
                data_reg <= wr_data;
                case (wr_addr)
                    DECODE_MODE:  decode_reg    <= wr_data;
                    INTENSITY:    intensity_reg <= wr_data[3:0];
                    SCAN_LIMIT:   scan_reg      <= wr_data[2:0];
                    SHUTDOWN:     shutdown_reg  <= wr_data[0];
                    DISPLAY_TEST: test_reg      <= wr_data[0];
                    default:      ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            logic [7:0] digit_reg;
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    digit_reg <= '0;
                end else if (frame_ok && wr_addr == DIGIT0 + 4'(gi)) begin
                    digit_reg <= wr_data;
                end
            end
            assign o_digits[8*gi+7 -: 8] = digit_reg;
        end
    endgenerate

    assign o_valid        = valid_reg;
    assign o_frame_err    = err_reg;
    assign o_addr         = addr_reg;
    assign o_data         = data_reg;
    assign o_decode_mode  = decode_reg;
    assign o_intensity    = intensity_reg;
    assign o_scan_limit   = scan_reg;
    assign o_shutdown_n   = shutdown_reg;
    assign o_display_test = test_reg;

`ifdef MAX7219_RECEIVER_DOUT_EN
    assign o_serial_dout = sr_reg[15];
    wire unused_ok = &{1'b0, din_rise, din_fall, clk_level, clk_fall, load_level};
`else
    wire unused_ok = &{1'b0, din_rise, din_fall, clk_level, clk_fall, load_level, sr_reg[15]};
`endif

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed bench for max7219_receiver with a transaction-level register model.
// Build with MAX7219_RECEIVER_DOUT_EN defined to also check the daisy-chain output.
module tb_max7219_receiver;

    localparam int SYNC = 2;
    localparam int HP   = 4;   // i_clk cycles per serial clock phase

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        sclk = 1'b0;
    logic        load = 1'b1;
    logic        o_valid, o_frame_err, o_shutdown_n, o_display_test;
    logic [3:0]  o_addr, o_intensity;
    logic [7:0]  o_data, o_decode_mode;
    logic [2:0]  o_scan_limit;
    logic [63:0] o_digits;
`ifdef MAX7219_RECEIVER_DOUT_EN
    logic        dout;
`endif

    max7219_receiver #(.SYNC_STAGES(SYNC)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_serial_din(din),
        .i_serial_clk(sclk),
        .i_serial_load(load),
`ifdef MAX7219_RECEIVER_DOUT_EN
        .o_serial_dout(dout),
`endif
        .o_valid(o_valid),
        .o_addr(o_addr),
        .o_data(o_data),
        .o_frame_err(o_frame_err),
        .o_digits(o_digits),
        .o_decode_mode(o_decode_mode),
        .o_intensity(o_intensity),
        .o_scan_limit(o_scan_limit),
        .o_shutdown_n(o_shutdown_n),
        .o_display_test(o_display_test)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rst_q = 1'b1;
    int valid_cnt = 0;
    int err_cnt   = 0;

    // Model state: what the display registers must hold.
    logic [63:0] m_digits;
    logic [7:0]  m_decode, m_data;
    logic [3:0]  m_intensity, m_addr;
    logic [2:0]  m_scan;
    logic        m_shutdown, m_test;

    // One outstanding frame outcome, due at a known cycle.
    int          p_cyc = -1;
    int          p_kind = 0;   // 1 = valid frame, 2 = short frame
    logic [3:0]  p_addr;
    logic [7:0]  p_data;
    logic        ev_valid, ev_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_digits = '0; m_decode = '0; m_data = '0; m_intensity = '0;
        m_addr = '0; m_scan = '0; m_shutdown = 1'b0; m_test = 1'b0;
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
        m_addr = a;
        m_data = d;
        if (a >= 4'h1 && a <= 4'h8) m_digits[8*int'(a)-1 -: 8] = d;
        else if (a == 4'h9) m_decode = d;
        else if (a == 4'hA) m_intensity = d[3:0];
        else if (a == 4'hB) m_scan = d[2:0];
        else if (a == 4'hC) m_shutdown = d[0];
        else if (a == 4'hF) m_test = d[0];
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            ev_valid = 1'b0;
            ev_err   = 1'b0;
            if (rst_q) begin
                model_clear();
                p_cyc = -1;
            end else if (cyc == p_cyc) begin
                if (p_kind == 1) begin
                    ev_valid = 1'b1;
                    model_write(p_addr, p_data);
                end else begin
                    ev_err = 1'b1;
                end
                p_cyc = -1;
            end
            check("valid",        64'(o_valid),        64'(ev_valid));
            check("frame_err",    64'(o_frame_err),    64'(ev_err));
            check("addr",         64'(o_addr),         64'(m_addr));
            check("data",         64'(o_data),         64'(m_data));
            check("digits",       o_digits,            m_digits);
            check("decode_mode",  64'(o_decode_mode),  64'(m_decode));
            check("intensity",    64'(o_intensity),    64'(m_intensity));
            check("scan_limit",   64'(o_scan_limit),   64'(m_scan));
            check("shutdown_n",   64'(o_shutdown_n),   64'(m_shutdown));
            check("display_test", 64'(o_display_test), 64'(m_test));
            if (o_valid === 1'b1) valid_cnt++;
            if (o_frame_err === 1'b1) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic schedule(input logic [31:0] bits, input int n);
        p_kind = (n >= 16) ? 1 : 2;
        p_addr = bits[11:8];
        p_data = bits[7:0];
        p_cyc  = cyc + SYNC + 1;
    endtask

    // mode 0: normal end, 1: load rises with the last clock edge, 2: abandoned (no load rise)
    task automatic send(input logic [31:0] bits, input int n, input int mode);
        int j;
        load = 1'b0;
        tick(HP);
        for (int k = 1; k <= n; k++) begin
            din  = bits[n-k];
            sclk = 1'b0;
            tick(HP);
            sclk = 1'b1;
            if (k == n && mode == 1) begin
                load = 1'b1;
                schedule(bits, n);
            end
            tick(HP);
`ifdef MAX7219_RECEIVER_DOUT_EN
            if (k >= 16) begin
                j = k - 15;
                check("serial_dout", 64'(dout), 64'(bits[n-j]));
            end
`else
            j = k;
`endif
        end
        sclk = 1'b0;
        if (mode == 0) begin
            load = 1'b1;
            schedule(bits, n);
        end
        tick(3 * HP);
        $display("frame bits=%h len=%0d mode=%0d -> addr=%h data=%h valid_cnt=%0d err_cnt=%0d",
                 bits, n, mode, o_addr, o_data, valid_cnt, err_cnt);
    endtask

    int v0, e0;

    initial begin
        tick(5);
        rst = 1'b0;
        tick(4);
        check("reset_digits", o_digits, 64'h0);
        check("reset_shutdown", 64'(o_shutdown_n), 64'h0);
        check("reset_valid_cnt", 64'(valid_cnt), 64'h0);

        // Intensity write at serial clock i_clk/8.
        v0 = valid_cnt;
        send(32'h0A05, 16, 0);
        check("t1_pulses", 64'(valid_cnt - v0), 64'd1);
        check("t1_intensity", 64'(o_intensity), 64'h5);
        check("t1_addr", 64'(o_addr), 64'hA);
        check("t1_data", 64'(o_data), 64'h05);

        // 20-bit burst: only the last 16 bits count.
        send(32'hF0305, 20, 0);
        check("t2_digit3", 64'(o_digits[23:16]), 64'h05);

        // Short frame leaves everything untouched.
        v0 = valid_cnt; e0 = err_cnt;
        send(32'hABC, 12, 0);
        check("t3_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("t3_valid_pulses", 64'(valid_cnt - v0), 64'd0);
        check("t3_intensity", 64'(o_intensity), 64'h5);
        check("t3_digit3", 64'(o_digits[23:16]), 64'h05);

        send(32'h0C01, 16, 0);
        check("t4_shutdown", 64'(o_shutdown_n), 64'h1);
        send(32'h0F01, 16, 0);
        check("t4_test", 64'(o_display_test), 64'h1);
        v0 = valid_cnt;
        send(32'h0D55, 16, 0);
        check("t4_noop_pulse", 64'(valid_cnt - v0), 64'd1);
        check("t4_noop_addr", 64'(o_addr), 64'hD);
        check("t4_noop_digits", o_digits[31:0], 32'h0005_0000);

        send(32'h09AA, 16, 0);
        check("t5_decode", 64'(o_decode_mode), 64'hAA);
        send(32'h0B0F, 16, 0);
        check("t5_scan", 64'(o_scan_limit), 64'h7);

        // Reset in the middle of a frame, then a clean frame.
        e0 = err_cnt;
        send(32'hFF, 8, 2);
        rst  = 1'b1;
        tick(2);
        load = 1'b1;
        tick(3);
        rst  = 1'b0;
        tick(6);
        check("t6_reset_intensity", 64'(o_intensity), 64'h0);
        send(32'h0301, 16, 0);
        check("t6_digit3", 64'(o_digits[23:16]), 64'h01);
        check("t6_no_err", 64'(err_cnt - e0), 64'd0);

        // Last serial clock edge coincident with load rising edge.
        v0 = valid_cnt;
        send(32'h0207, 16, 1);
        check("t7_pulse", 64'(valid_cnt - v0), 64'd1);
        check("t7_digit2", 64'(o_digits[15:8]), 64'h07);

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
